// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage multi-cycle multiply/divide with architectural HI/LO registers
// Optional build macro MULDIV_RADIX4_EN: divider retires two quotient bits per cycle (16 iterations).
module ex_muldiv_unit #(
   parameter int MUL_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        op_valid,
   input  logic [5:0]  alu_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        stall,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [5:0] ALU_MTHI  = 6'h11;
   localparam logic [5:0] ALU_MTLO  = 6'h13;
   localparam logic [5:0] ALU_MULT  = 6'h18;
   localparam logic [5:0] ALU_MULTU = 6'h19;
   localparam logic [5:0] ALU_DIV   = 6'h1A;
   localparam logic [5:0] ALU_DIVU  = 6'h1B;
`ifdef MULDIV_RADIX4_EN
   localparam logic [31:0] DIV_ITERS = 32'd16;
`else
   localparam logic [31:0] DIV_ITERS = 32'd32;
`endif

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] op_a, op_b, rem, quo;
   logic        signed_op, neg_q, neg_r;
   logic        is_mul, is_div, sdiv;
   logic [31:0] mag_a, mag_b, q_fin, r_fin;
   logic [63:0] ext_a, ext_b, prod, step1, step;

   // one restoring-division step: shift in the next dividend bit, subtract divisor if it fits
   function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q, input logic [31:0] d);
      logic [32:0] t, diff;
      t    = {r, q[31]};
      diff = t - {1'b0, d};
      return (t >= {1'b0, d}) ? {diff[31:0], q[30:0], 1'b1} : {t[31:0], q[30:0], 1'b0};
   endfunction

   // decode, operand magnitudes, product and next divider state
   always_comb begin
      is_mul = op_valid && !flush && (alu_op == ALU_MULT || alu_op == ALU_MULTU);
      is_div = op_valid && !flush && (alu_op == ALU_DIV || alu_op == ALU_DIVU);
      sdiv   = alu_op == ALU_DIV;
      mag_a  = sdiv && src_a[31] ? -src_a : src_a;
      mag_b  = sdiv && src_b[31] ? -src_b : src_b;
      ext_a  = {{32{signed_op & op_a[31]}}, op_a};
      ext_b  = {{32{signed_op & op_b[31]}}, op_b};
      prod   = ext_a * ext_b;
      step1  = div_step(rem, quo, op_b);
`ifdef MULDIV_RADIX4_EN
      step   = div_step(step1[63:32], step1[31:0], op_b);
`else
      step   = step1;
`endif
      q_fin  = neg_q ? -step[31:0] : step[31:0];
      r_fin  = neg_r ? -step[63:32] : step[63:32];
      stall  = (state == IDLE && (is_mul || is_div)) || state == MUL || state == DIV;
   end

   assign busy         = state != IDLE;
   assign result_valid = state == DONE;

   // sequencing FSM; HI/LO are written only on completion, MTHI/MTLO or divide-by-zero
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rem       <= '0;
         quo       <= '0;
         signed_op <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (is_mul) begin
                  op_a      <= src_a;
                  op_b      <= src_b;
                  signed_op <= alu_op == ALU_MULT;
                  cnt       <= 32'(MUL_STAGES);
                  state     <= MUL;
               end else if (is_div && src_b == '0) begin
                  hi    <= src_a;
                  lo    <= '1;
                  state <= DONE;
               end else if (is_div) begin
                  op_b  <= mag_b;
                  quo   <= mag_a;
                  rem   <= '0;
                  neg_q <= sdiv && (src_a[31] ^ src_b[31]);
                  neg_r <= sdiv && src_a[31];
                  cnt   <= DIV_ITERS;
                  state <= DIV;
               end else if (op_valid && alu_op == ALU_MTHI) begin
                  hi <= src_a;
               end else if (op_valid && alu_op == ALU_MTLO) begin
                  lo <= src_a;
               end
            end
            MUL: begin
               cnt <= cnt - 32'd1;
               if (cnt == 32'd1) begin
                  {hi, lo} <= prod;
                  state    <= DONE;
               end
            end
            DIV: begin
               rem <= step[63:32];
               quo <= step[31:0];
               cnt <= cnt - 32'd1;
               if (cnt == 32'd1) begin
                  lo    <= q_fin;
                  hi    <= r_fin;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against an arithmetic reference
module tb_ex_muldiv_unit;
   localparam logic [5:0] ALU_ADD   = 6'h20;
   localparam logic [5:0] ALU_MTHI  = 6'h11;
   localparam logic [5:0] ALU_MTLO  = 6'h13;
   localparam logic [5:0] ALU_MULT  = 6'h18;
   localparam logic [5:0] ALU_MULTU = 6'h19;
   localparam logic [5:0] ALU_DIV   = 6'h1A;
   localparam logic [5:0] ALU_DIVU  = 6'h1B;
   localparam int MUL_ST = 2;
`ifdef MULDIV_RADIX4_EN
   localparam int DIV_ST = 17;
`else
   localparam int DIV_ST = 33;
`endif

   logic        clk = 0, rst = 1, flush = 0, op_valid = 0;
   logic [5:0]  alu_op = '0;
   logic [31:0] src_a = '0, src_b = '0;
   logic        stall, busy, result_valid;
   logic [31:0] hi, lo;
   int compared = 0, mismatched = 0;

   ex_muldiv_unit #(.MUL_STAGES(MUL_ST)) dut (
      .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .alu_op(alu_op),
      .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
      .result_valid(result_valid), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int q, r;
      if (op == ALU_MULT) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end
      if (op == ALU_MULTU) return {32'b0, a} * {32'b0, b};
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (op == ALU_DIVU) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
   endfunction

   function automatic int exp_stall(input logic [5:0] op, input logic [31:0] b);
      if (op == ALU_MULT || op == ALU_MULTU) return 1 + MUL_ST;
      return (b == 0) ? 1 : DIV_ST;
   endfunction

   // holds the instruction in EX while stalled (and through DONE), then retires it
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic rv_d, output logic rv_a, output logic busy_a,
                        output logic [31:0] h, output logic [31:0] l);
      n = 0;
      @(negedge clk);
      op_valid = 1; alu_op = op; src_a = a; src_b = b;
      #1;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      rv_d = result_valid; h = hi; l = lo;
      @(negedge clk);
      op_valid = 0; alu_op = ALU_ADD;
      #1;
      rv_a = result_valid; busy_a = busy;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      compared++;
      if ({stall, busy, result_valid, hi, lo} !== 67'b0) begin
         mismatched++;
         $display("FAIL reset: stall=%b busy=%b rv=%b hi=%h lo=%h, required all zero", stall, busy, result_valid, hi, lo);
      end
   endtask

   task automatic test_directed(input string name, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int es, input logic [31:0] eh, input logic [31:0] el);
      int n;
      logic rv_d, rv_a, busy_a;
      logic [31:0] h, l;
      issue(op, a, b, n, rv_d, rv_a, busy_a, h, l);
      compared++;
      if (n !== es) begin
         mismatched++;
         $display("FAIL %s stall cycles: got %0d, required %0d", name, n, es);
      end
      compared++;
      if ({h, l} !== {eh, el}) begin
         mismatched++;
         $display("FAIL %s hi/lo: got %h/%h, required %h/%h", name, h, l, eh, el);
      end
      compared++;
      if ({rv_d, rv_a, busy_a} !== 3'b100) begin
         mismatched++;
         $display("FAIL %s rv pulse/busy: got rv_done=%b rv_after=%b busy_after=%b, required 1/0/0", name, rv_d, rv_a, busy_a);
      end
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      op_valid = 1; alu_op = ALU_MTHI; src_a = 32'hAAAA0000;
      #1;
      compared++;
      if (stall !== 1'b0) begin
         mismatched++;
         $display("FAIL mthi stall: got %b, required 0", stall);
      end
      @(negedge clk);
      alu_op = ALU_MTLO; src_a = 32'h00005555;
      #1;
      compared++;
      if (hi !== 32'hAAAA0000 || stall !== 1'b0) begin
         mismatched++;
         $display("FAIL mthi write: hi=%h stall=%b, required aaaa0000/0", hi, stall);
      end
      @(negedge clk);
      alu_op = ALU_MTHI; src_a = 32'h12121212; flush = 1;
      #1;
      compared++;
      if (lo !== 32'h00005555) begin
         mismatched++;
         $display("FAIL mtlo write: lo=%h, required 00005555", lo);
      end
      @(negedge clk);
      op_valid = 0; flush = 0; alu_op = ALU_ADD;
      #1;
      compared++;
      if (hi !== 32'hAAAA0000) begin
         mismatched++;
         $display("FAIL flushed mthi: hi=%h, required aaaa0000", hi);
      end
   endtask

   task automatic test_flush();
      int rv_seen = 0;
      @(negedge clk);
      op_valid = 1; alu_op = ALU_DIVU; src_a = $urandom; src_b = 32'd3;
      repeat (11) begin
         @(negedge clk);
         #1;
         rv_seen += int'(result_valid);
      end
      flush = 1;
      #1;
      compared++;
      if (stall !== 1'b1) begin
         mismatched++;
         $display("FAIL flush pre: stall=%b, required 1", stall);
      end
      @(negedge clk);
      flush = 0; op_valid = 0; alu_op = ALU_ADD;
      #1;
      compared++;
      if ({stall, busy, result_valid} !== 3'b000 || hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin
         mismatched++;
         $display("FAIL flush post: stall=%b busy=%b rv=%b hi=%h lo=%h, required 0/0/0 aaaa0000/00005555",
                  stall, busy, result_valid, hi, lo);
      end
      repeat (40) begin
         @(negedge clk);
         #1;
         rv_seen += int'(result_valid);
      end
      compared++;
      if (rv_seen !== 0 || hi !== 32'hAAAA0000 || lo !== 32'h00005555) begin
         mismatched++;
         $display("FAIL flush discard: rv pulses=%0d hi=%h lo=%h, required 0 aaaa0000/00005555", rv_seen, hi, lo);
      end
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      op_valid = 1; alu_op = ALU_MULT; src_a = 32'h7; src_b = 32'h9;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0; op_valid = 0; alu_op = ALU_ADD;
      #1;
      compared++;
      if ({hi, lo, busy, stall, result_valid} !== 67'b0) begin
         mismatched++;
         $display("FAIL rst mid-mul: hi=%h lo=%h busy=%b stall=%b rv=%b, required all zero", hi, lo, busy, stall, result_valid);
      end
   endtask

   task automatic test_random(input int iters);
      logic [5:0] ops [4] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
      for (int i = 0; i < iters; i++) begin
         int n, sel;
         logic rv_d, rv_a, busy_a;
         logic [31:0] a, b, h, l;
         logic [63:0] e;
         logic [5:0] op;
         op  = ops[$urandom_range(0, 3)];
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
         if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         e = model(op, a, b);
         issue(op, a, b, n, rv_d, rv_a, busy_a, h, l);
         compared++;
         if ({h, l} !== e || n !== exp_stall(op, b) || {rv_d, rv_a, busy_a} !== 3'b100) begin
            mismatched++;
            $display("FAIL random op=%h a=%h b=%h: hi/lo=%h/%h stalls=%0d rv=%b%b busy=%b, required %h/%h stalls=%0d rv=10 busy=0",
                     op, a, b, h, l, n, rv_d, rv_a, busy_a, e[63:32], e[31:0], exp_stall(op, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed("mult_neg", ALU_MULT, 32'hFFFFFFFD, 32'd7, 1 + MUL_ST, 32'hFFFFFFFF, 32'hFFFFFFEB);
      test_directed("multu_max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1 + MUL_ST, 32'hFFFFFFFE, 32'h00000001);
      test_directed("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'd2, DIV_ST, 32'hFFFFFFFF, 32'hFFFFFFFD);
      test_directed("divu_7_2", ALU_DIVU, 32'd7, 32'd2, DIV_ST, 32'd1, 32'd3);
      test_directed("div_by_zero", ALU_DIV, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFFFFFF);
      test_directed("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_ST, 32'h0, 32'h80000000);
      test_mthi_mtlo();
      test_flush();
      test_rst_mid();
      test_random(40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
